// File: rtl/btb_pkg.sv
// Shared types, derived widths and the counter update rule for the branch target buffer.
// The localparams here are the build geometry; module parameters default to them.
package btb_pkg;
  localparam int BTB_PC_W   = 10;
  localparam int BTB_SETS   = 8;
  localparam int BTB_WAYS   = 2;
  localparam int BTB_HIST_W = 3;

  localparam int IDX_W = $clog2(BTB_SETS);
  localparam int TAG_W = BTB_PC_W - IDX_W;
  localparam int WAY_W = (BTB_WAYS > 1) ? $clog2(BTB_WAYS) : 1;

  typedef logic [BTB_HIST_W-1:0] hist_t;

  localparam hist_t WEAK_TAKEN = {1'b1, {(BTB_HIST_W-1){1'b0}}};

  typedef struct packed {
    logic                valid;
    logic [TAG_W-1:0]    tag;
    logic [BTB_PC_W-1:0] target;
    hist_t               counter;
  } entry_t;

  function automatic hist_t sat_update(input hist_t counter, input logic taken);
    if (taken) return (&counter) ? counter : counter + 1'b1;
    else       return (counter == '0) ? counter : counter - 1'b1;
  endfunction
endpackage

// File: rtl/btb_set_match.sv
// Combinational tag compare across all ways of one set; reports hit, way, entry
// and whether more than one way matched.
module btb_set_match
  import btb_pkg::*;
#(
  parameter int WAYS = BTB_WAYS
) (
  input  entry_t [WAYS-1:0] set_entries,
  input  logic [TAG_W-1:0]  tag,
  output logic              hit,
  output logic [WAY_W-1:0]  way,
  output entry_t            entry,
  output logic              multi_hit
);

  always_comb begin
    hit       = 1'b0;
    way       = '0;
    entry     = '0;
    multi_hit = 1'b0;
    for (int w = 0; w < WAYS; w++) begin
      if (set_entries[w].valid && set_entries[w].tag == tag) begin
        if (hit) multi_hit = 1'b1;
        hit   = 1'b1;
        way   = WAY_W'(w);
        entry = set_entries[w];
      end
    end
  end

endmodule

// File: rtl/branch_target_buffer.sv
// Set-associative branch target buffer with saturating direction counters and
// per-set round-robin allocation. Optional same-cycle bypass: define BTB_BYPASS_EN.
module branch_target_buffer
  import btb_pkg::*;
#(
  parameter int PC_W   = BTB_PC_W,
  parameter int SETS   = BTB_SETS,
  parameter int WAYS   = BTB_WAYS,
  parameter int HIST_W = BTB_HIST_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic [PC_W-1:0]   pc,
  output logic              read_hit,
  output logic              read_taken,
  output logic [HIST_W-1:0] read_history,
  output logic [PC_W-1:0]   jump_addr,
  input  logic              we,
  input  logic [PC_W-1:0]   update_pc,
  input  logic              branch_taken,
  input  logic [PC_W-1:0]   wb_addr,
  output logic [HIST_W-1:0] update_history,
  output logic              evict,
  output logic [PC_W-1:0]   evict_pc
);

  entry_t [WAYS-1:0] entries_reg [SETS];
  logic [WAY_W-1:0]  rr_reg [SETS];
  logic              evict_reg;
  logic [PC_W-1:0]   evict_pc_reg;

  logic [IDX_W-1:0] rd_idx, up_idx;
  logic [TAG_W-1:0] rd_tag, up_tag;
  logic             rd_hit, up_hit, rd_multi, up_multi;
  logic [WAY_W-1:0] rd_way, up_way, upd_way;
  entry_t           rd_entry, up_entry, upd_entry_next, victim, sel_entry;
  logic             upd_write, sel_hit;

  assign rd_idx = pc[IDX_W-1:0];
  assign rd_tag = pc[PC_W-1:IDX_W];
  assign up_idx = update_pc[IDX_W-1:0];
  assign up_tag = update_pc[PC_W-1:IDX_W];

  btb_set_match #(.WAYS(WAYS)) u_read_match (
    .set_entries(entries_reg[rd_idx]),
    .tag        (rd_tag),
    .hit        (rd_hit),
    .way        (rd_way),
    .entry      (rd_entry),
    .multi_hit  (rd_multi)
  );

  btb_set_match #(.WAYS(WAYS)) u_update_match (
    .set_entries(entries_reg[up_idx]),
    .tag        (update_pc[PC_W-1:IDX_W]),
    .hit        (up_hit),
    .way        (up_way),
    .entry      (up_entry),
    .multi_hit  (up_multi)
  );

  // A not-taken miss never allocates, so it leaves the array untouched.
  assign upd_write = we && (up_hit || branch_taken);
  assign upd_way   = up_hit ? up_way : rr_reg[up_idx];
  assign victim    = entries_reg[up_idx][rr_reg[up_idx]];

  always_comb begin
    upd_entry_next = up_entry;
    if (up_hit) begin
      upd_entry_next.counter = sat_update(up_entry.counter, branch_taken);
      if (branch_taken) upd_entry_next.target = wb_addr;
    end else begin
      upd_entry_next.valid   = 1'b1;
      upd_entry_next.tag     = up_tag;
      upd_entry_next.target  = wb_addr;
      upd_entry_next.counter = WEAK_TAKEN;
    end
  end

  always_comb begin
    sel_hit   = rd_hit;
    sel_entry = rd_entry;
`ifdef BTB_BYPASS_EN
    if (we && update_pc == pc) begin
      if (flush) begin
        sel_hit   = 1'b0;
        sel_entry = '0;
      end else if (upd_write) begin
        sel_hit   = 1'b1;
        sel_entry = upd_entry_next;
      end
    end
`endif
    read_hit     = sel_hit;
    read_history = sel_hit ? sel_entry.counter : '0;
    read_taken   = sel_hit ? sel_entry.counter[HIST_W-1] : 1'b0;
    jump_addr    = sel_hit ? sel_entry.target : '0;
  end

  assign update_history = up_hit ? up_entry.counter : '0;
  assign evict          = evict_reg;
  assign evict_pc       = evict_pc_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int s = 0; s < SETS; s++) begin
        entries_reg[s] <= '0;
        rr_reg[s]      <= '0;
      end
      evict_reg    <= 1'b0;
      evict_pc_reg <= '0;
    end else begin
      evict_reg    <= 1'b0;
      evict_pc_reg <= '0;
      if (flush) begin
        for (int s = 0; s < SETS; s++) begin
          for (int w = 0; w < WAYS; w++) entries_reg[s][w].valid <= 1'b0;
          rr_reg[s] <= '0;
        end
      end else if (upd_write) begin
        entries_reg[up_idx][upd_way] <= upd_entry_next;
        if (!up_hit) begin
          rr_reg[up_idx] <= (WAYS == 1) ? '0 : rr_reg[up_idx] + 1'b1;
          evict_reg      <= victim.valid;
          evict_pc_reg   <= victim.valid ? {victim.tag, up_idx} : '0;
        end
      end
    end
  end

  // Allocation only happens on a miss, so duplicate tags within a set must never appear.
  a_single_hit: assert property (@(posedge clk) disable iff (rst) !(rd_multi || up_multi));
  a_read_way:   assert property (@(posedge clk) disable iff (rst)
                                 !rd_hit || entries_reg[rd_idx][rd_way] == rd_entry);

endmodule

// File: tb/tb_branch_target_buffer.sv
// Scoreboard bench for branch_target_buffer: expected lookup/evict results are queued
// when stimulus is driven and compared when the outputs are sampled.
module tb_branch_target_buffer;
  logic       clk, rst, flush, we, branch_taken;
  logic [9:0] pc, update_pc, wb_addr, jump_addr, evict_pc;
  logic       read_hit, read_taken, evict;
  logic [2:0] read_history, update_history;

  int checks_total  = 0;
  int checks_passed = 0;

  typedef struct { bit hit; bit [2:0] hist; bit [9:0] tgt; bit [2:0] uhist; } rd_t;
  typedef struct { bit ev; bit [9:0] epc; } ev_t;
  rd_t rd_q[$];
  ev_t ev_q[$];

  branch_target_buffer dut (
    .clk(clk), .rst(rst), .flush(flush), .pc(pc),
    .read_hit(read_hit), .read_taken(read_taken), .read_history(read_history),
    .jump_addr(jump_addr), .we(we), .update_pc(update_pc), .branch_taken(branch_taken),
    .wb_addr(wb_addr), .update_history(update_history), .evict(evict), .evict_pc(evict_pc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks_total++;
    if (got !== exp) $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    else checks_passed++;
  endtask

  task automatic step(input bit f, input bit w, input bit [9:0] upc, input bit bt,
                      input bit [9:0] wb, input bit [9:0] lpc,
                      input bit e_hit, input bit [2:0] e_hist, input bit [9:0] e_tgt,
                      input bit [2:0] e_uh, input bit e_ev, input bit [9:0] e_evpc);
    rd_t r;
    ev_t e;
    @(negedge clk);
    flush = f; we = w; update_pc = upc; branch_taken = bt; wb_addr = wb; pc = lpc;
    rd_q.push_back('{e_hit, e_hist, e_tgt, e_uh});
    #1;
    r = rd_q.pop_front();
    check_eq("read_hit", read_hit, r.hit);
    check_eq("read_history", read_history, r.hist);
    check_eq("read_taken", read_taken, r.hit ? r.hist[2] : 1'b0);
    check_eq("jump_addr", jump_addr, r.tgt);
    check_eq("update_history", update_history, r.uhist);
    if (ev_q.size() > 0) begin
      e = ev_q.pop_front();
      check_eq("evict", evict, e.ev);
      if (e.ev) check_eq("evict_pc", evict_pc, e.epc);
    end
    ev_q.push_back('{e_ev, e_evpc});
    $display("step flush=%0b we=%0b upc=%03h bt=%0b wb=%03h pc=%03h hit=%0b hist=%0d tgt=%03h uh=%0d ev=%0b evpc=%03h",
             f, w, upc, bt, wb, lpc, read_hit, read_history, jump_addr, update_history, evict, evict_pc);
  endtask

  // 0x3FF is never allocated, so it serves as an idle lookup / update address.
  task automatic upd(input bit [9:0] upc, input bit bt, input bit [9:0] wb,
                     input bit [2:0] e_uh, input bit e_ev, input bit [9:0] e_evpc);
    step(1'b0, 1'b1, upc, bt, wb, 10'h3FF, 1'b0, 3'd0, 10'h0, e_uh, e_ev, e_evpc);
  endtask

  task automatic look(input bit [9:0] lpc, input bit e_hit, input bit [2:0] e_hist,
                      input bit [9:0] e_tgt);
    step(1'b0, 1'b0, 10'h3FF, 1'b0, 10'h0, lpc, e_hit, e_hist, e_tgt, 3'd0, 1'b0, 10'h0);
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; we = 1'b0; branch_taken = 1'b0;
    pc = 10'h00F; update_pc = 10'h3FF; wb_addr = '0;
    @(negedge clk);
    #1;
    check_eq("reset_read_hit", read_hit, 1'b0);
    check_eq("reset_jump_addr", jump_addr, 10'h0);
    check_eq("reset_read_history", read_history, 3'd0);
    check_eq("reset_evict", evict, 1'b0);
    check_eq("reset_evict_pc", evict_pc, 10'h0);
    rst = 1'b0;
    ev_q.push_back('{1'b0, 10'h0});

    // allocation, counter saturation up and down
    upd(10'h00F, 1'b1, 10'h00A, 3'd0, 1'b0, 10'h0);
    look(10'h00F, 1'b1, 3'd4, 10'h00A);
    for (int i = 4; i <= 7; i++) upd(10'h00F, 1'b1, 10'h00A, 3'(i), 1'b0, 10'h0);
    look(10'h00F, 1'b1, 3'd7, 10'h00A);
    for (int i = 7; i >= 0; i--) upd(10'h00F, 1'b0, 10'h155, 3'(i), 1'b0, 10'h0);
    upd(10'h00F, 1'b0, 10'h155, 3'd0, 1'b0, 10'h0);
    look(10'h00F, 1'b1, 3'd0, 10'h00A);

    // flush alone, then round-robin eviction in set 7 with back-to-back pulses
    step(1'b1, 1'b0, 10'h3FF, 1'b0, 10'h0, 10'h00F, 1'b1, 3'd0, 10'h00A, 3'd0, 1'b0, 10'h0);
    upd(10'h007, 1'b1, 10'h111, 3'd0, 1'b0, 10'h0);
    upd(10'h00F, 1'b1, 10'h122, 3'd0, 1'b0, 10'h0);
    upd(10'h017, 1'b1, 10'h133, 3'd0, 1'b1, 10'h007);
    upd(10'h01F, 1'b1, 10'h144, 3'd0, 1'b1, 10'h00F);
    upd(10'h027, 1'b1, 10'h155, 3'd0, 1'b1, 10'h017);
    look(10'h007, 1'b0, 3'd0, 10'h0);
    look(10'h01F, 1'b1, 3'd4, 10'h144);
    look(10'h027, 1'b1, 3'd4, 10'h155);

    // not-taken miss allocates nothing; flush drops a same-cycle update
    upd(10'h020, 1'b0, 10'h0AA, 3'd0, 1'b0, 10'h0);
    look(10'h020, 1'b0, 3'd0, 10'h0);
    step(1'b1, 1'b1, 10'h040, 1'b1, 10'h1AB, 10'h3FF, 1'b0, 3'd0, 10'h0, 3'd0, 1'b0, 10'h0);
    look(10'h01F, 1'b0, 3'd0, 10'h0);
    look(10'h027, 1'b0, 3'd0, 10'h0);
    look(10'h040, 1'b0, 3'd0, 10'h0);

    // same-cycle update and lookup
`ifdef BTB_BYPASS_EN
    step(1'b0, 1'b1, 10'h030, 1'b1, 10'h100, 10'h030, 1'b1, 3'd4, 10'h100, 3'd0, 1'b0, 10'h0);
`else
    step(1'b0, 1'b1, 10'h030, 1'b1, 10'h100, 10'h030, 1'b0, 3'd0, 10'h0, 3'd0, 1'b0, 10'h0);
`endif
    look(10'h030, 1'b1, 3'd4, 10'h100);

    // reset while an evict pulse is pending
    upd(10'h038, 1'b1, 10'h222, 3'd0, 1'b0, 10'h0);
    upd(10'h040, 1'b1, 10'h333, 3'd0, 1'b1, 10'h030);
    @(posedge clk);
    #2;
    rst = 1'b1; we = 1'b0; pc = 10'h038;
    #1;
    ev_q.delete();
    check_eq("rst_evict", evict, 1'b0);
    check_eq("rst_evict_pc", evict_pc, 10'h0);
    check_eq("rst_read_hit", read_hit, 1'b0);
    $display("async reset: evict=%0b evict_pc=%03h hit=%0b", evict, evict_pc, read_hit);
    @(negedge clk);
    rst = 1'b0;
    ev_q.push_back('{1'b0, 10'h0});
    look(10'h038, 1'b0, 3'd0, 10'h0);
    look(10'h040, 1'b0, 3'd0, 10'h0);

    $display("%0d/%0d checks passed", checks_passed, checks_total);
    $finish;
  end

endmodule

// File: doc/branch_target_buffer.md
# branch_target_buffer

Parametrised, set-associative branch target buffer with saturating-counter direction history and round-robin replacement. It generalises the single-entry branch predictor cache to configurable PC width, set count, way count and history width, and adds an explicit eviction report and a flush. It sits beside the fetch stage: the lookup port is driven by fetch `pc`, and the update port is driven by the branch resolution stage.

## Interface
- `PC_W`, 10: PC and target width in bits.
- `SETS`, 8: number of sets; power of two, ≥2.
- `WAYS`, 2: ways per set; power of two, ≥1.
- `HIST_W`, 3: saturating counter width, ≥2.

Ports:
- `clk` in 1: single clock, rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `flush` in 1: invalidates all entries at the next edge.
- `pc` in PC_W: lookup address.
- `read_hit` out 1: lookup hit.
- `read_taken` out 1: predicted taken; equals the MSB of `read_history` when hit, 0 on miss.
- `read_history` out HIST_W: counter of the hit entry; 0 on miss.
- `jump_addr` out PC_W: target of the hit entry; 0 on miss.
- `we` in 1: update strobe.
- `update_pc` in PC_W: address of the resolved branch.
- `branch_taken` in 1: resolved direction.
- `wb_addr` in PC_W: resolved target.
- `update_history` out HIST_W: pre-update counter of the `update_pc` entry; 0 on miss.
- `evict` out 1: registered pulse, one cycle, reporting that an allocation displaced a valid entry.
- `evict_pc` out PC_W: reconstructed PC of the displaced entry, valid while `evict`=1.

## Operation
- Set index is `pc[IDX_W-1:0]`, with IDX_W=log2(SETS). The tag is the remaining upper bits. Each entry holds valid, tag, target and counter.
- Lookup is combinational from the storage arrays. At most one way can match; if more than one matches, that is a design error and is flagged by an assertion.
- Update (`we`=1) when `update_pc` hits:
  - The counter saturates: +1 if `branch_taken`, −1 otherwise. It clamps at 2^HIST_W−1 and at 0.
  - The target is overwritten with `wb_addr` only when `branch_taken`=1.
- Update when `update_pc` misses and `branch_taken`=1:
  - Allocate the way selected by the set's round-robin pointer.
  - Write tag and target; set the counter to weakly-taken, 2^(HIST_W−1).
  - Advance the pointer modulo WAYS.
  - If the victim was valid, assert `evict` with its `evict_pc` on the following cycle.
- Update when `update_pc` misses and `branch_taken`=0: no state change.
- `flush`=1 clears all valid bits and all round-robin pointers. Flush has priority over a same-cycle `we`, and that update is dropped.
- Reset: all valid bits 0, pointers 0, `evict`=0, `evict_pc`=0. Lookup outputs therefore read 0 or miss.

## Timing
- Lookup latency is 0 cycles (combinational from `pc`).
- An update becomes visible to lookups from the cycle after the `we` edge, unless bypass is enabled (see Configuration).
- `evict` and `evict_pc` are registered, 1 cycle after the allocating edge. Back-to-back evicting updates produce back-to-back pulses with no loss.
- `update_history` is combinational and reflects pre-edge state.
- Reset asserted mid-operation clears state immediately. Any update pending in that cycle is discarded, and a pending `evict` drops to 0.

## Configuration
- `BTB_BYPASS_EN` defined: when `we`=1 and `update_pc`==`pc` in the same cycle, the lookup outputs show the post-update values combinationally. A not-taken miss still reads as a miss. Flush overrides the bypass and the lookup reads as a miss.
- `BTB_BYPASS_EN` undefined: the lookup shows pre-edge array state only.

## Structure
- Package `btb_pkg`:
  - entry struct: valid, tag, target, counter;
  - function `sat_update(counter, taken)`;
  - localparams derived from the parameters: IDX_W, TAG_W, WAY_W.
- Sub-module `btb_set_match`: combinational tag compare across WAYS for one index. It returns hit, way and entry, and is instantiated twice, once for lookup and once for update.

## Test plan
- Reset, then `pc`=0x00F → `read_hit`=0, `jump_addr`=0, `evict`=0.
- Update taken, `update_pc`=0x00F, `wb_addr`=0x00A; next cycle `pc`=0x00F → hit, `jump_addr`=0x00A, `read_history`=4.
- Three further taken updates at 0x00F → counter reads 5, 6, 7 and stays at 7. Then eight not-taken updates → counter steps down to 0 and stays at 0; the target remains 0x00A.
- With SETS=8 and WAYS=2, allocate taken branches at 0x007, 0x00F, 0x017 → the third allocation evicts 0x007. `evict`=1 for one cycle with `evict_pc`=0x007; a lookup at 0x007 then misses.
- Not-taken update at unseen 0x020 → no allocation and no `evict`. Then `flush` asserted together with `we` → all lookups miss and the dropped update does not appear.
- Same-cycle `we` at 0x030 (taken, `wb_addr`=0x100) and `pc`=0x030 → with `BTB_BYPASS_EN` defined, hit and `jump_addr`=0x100 in that cycle; undefined, a miss in that cycle and a hit in the next.
